z80fi_insn_capture: RTL and testbench

- Upstream of every z80fi_insn_spec_* module.
- Watches the core's per-cycle retirement events (instruction start, opcode/operand byte fetches, memory writes, instruction end) and assembles one z80fi retirement packet per instruction.
- The packet carries the instruction bytes, length, pre-instruction register snapshot, up to two memory writes and post-instruction IP.
- The packet is what the spec modules and the checker consume.

---
 rtl/z80fi_insn_capture_pkg.sv | 38 +++
 rtl/z80fi_access_slots.sv | 68 ++++++
 rtl/z80fi_insn_capture.sv | 180 ++++++++++++++++++
 tb/tb_z80fi_insn_capture.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_insn_capture_pkg.sv
// z80fi_insn_capture_pkg: shared types, widths and helpers for the z80fi capture block.
//   state_e  : capture FSM encoding (ST_IDLE, ST_COLLECT)
//   slot_t   : one recorded memory access (valid, address, data)
//   regs_t   : register snapshot taken at instruction start
//   put_byte : inserts a byte into the little-endian instruction word
package z80fi_insn_capture_pkg;

    typedef enum logic {ST_IDLE, ST_COLLECT} state_e;

    localparam int Z80FI_INSN_W = 32;
    localparam int Z80FI_LEN_W  = 3;
    localparam int Z80FI_REG_W  = 16;
    localparam int Z80FI_ADDR_W = 16;
    localparam int Z80FI_DATA_W = 8;

    typedef struct packed {
        logic                    v;
        logic [Z80FI_ADDR_W-1:0] addr;
        logic [Z80FI_DATA_W-1:0] data;
    } slot_t;

    typedef struct packed {
        logic [Z80FI_REG_W-1:0] ip;
        logic [Z80FI_REG_W-1:0] bc;
        logic [Z80FI_REG_W-1:0] de;
        logic [Z80FI_REG_W-1:0] hl;
        logic [Z80FI_REG_W-1:0] sp;
    } regs_t;

    function automatic logic [Z80FI_INSN_W-1:0] put_byte(
        input logic [Z80FI_INSN_W-1:0] word,
        input logic [1:0]              idx,
        input logic [Z80FI_DATA_W-1:0] b
    );
        put_byte = word | (Z80FI_INSN_W'(b) << {idx, 3'b000});
    endfunction

endpackage

// File: rtl/z80fi_access_slots.sv
// z80fi_access_slots: two-entry memory access recorder with overflow detection.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : instruction start this cycle
//   fin                 : instruction finalises this cycle (packet outputs load)
//   acc, acc_addr/data  : access accepted into the packet being collected
//   v1/a1/d1, v2/a2/d2  : packet outputs for the first and second access
//   ovf                 : combinational pulse, a third access was dropped
module z80fi_access_slots
    import z80fi_insn_capture_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    fin,
    input  logic                    acc,
    input  logic [Z80FI_ADDR_W-1:0] acc_addr,
    input  logic [Z80FI_DATA_W-1:0] acc_data,
    output logic                    v1,
    output logic [Z80FI_ADDR_W-1:0] a1,
    output logic [Z80FI_DATA_W-1:0] d1,
    output logic                    v2,
    output logic [Z80FI_ADDR_W-1:0] a2,
    output logic [Z80FI_DATA_W-1:0] d2,
    output logic                    ovf
);

    slot_t s1_q, s1_d, s2_q, s2_d, o1_q, o1_d, o2_q, o2_d;
    slot_t c1, c2, u1, u2;
    logic  clr;

    // A start without a simultaneous finish clears before this cycle's access
    // lands, so the access belongs to the new instruction. With a finish the
    // access belongs to the retiring packet and the working slots clear after.
    always_comb begin
        clr  = start && !fin;
        c1   = clr ? '0 : s1_q;
        c2   = clr ? '0 : s2_q;
        ovf  = acc && c1.v && c2.v;
        u1   = (acc && !c1.v) ? slot_t'{v: 1'b1, addr: acc_addr, data: acc_data} : c1;
        u2   = (acc && c1.v && !c2.v) ? slot_t'{v: 1'b1, addr: acc_addr, data: acc_data} : c2;
        s1_d = (start && fin) ? '0 : u1;
        s2_d = (start && fin) ? '0 : u2;
        o1_d = fin ? u1 : (clr ? '0 : o1_q);
        o2_d = fin ? u2 : (clr ? '0 : o2_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            o1_q <= '0;
            o2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            o1_q <= o1_d;
            o2_q <= o2_d;
        end
    end

    assign v1 = o1_q.v;
    assign a1 = o1_q.addr;
    assign d1 = o1_q.data;
    assign v2 = o2_q.v;
    assign a2 = o2_q.addr;
    assign d2 = o2_q.data;

endmodule

// File: rtl/z80fi_insn_capture.sv
// z80fi_insn_capture: assembles one z80fi retirement packet per retired instruction.
//   Inputs : core_insn_start/fetch/mem_wr/insn_end strobes, fetch byte, write
//            address/data, core_ip and bc/de/hl/sp register values.
//   Outputs: z80fi_valid (1-cycle strobe, cycle after core_insn_end), packet
//            fields (insn bytes, len, register snapshot, ip_out, two write
//            slots) held until the next start, sticky capture_err.
//   Optional: define Z80FI_MEM_RD_EN to add core_mem_rd* inputs and two
//            z80fi_mem_rd* read slots recorded like the write slots.
module z80fi_insn_capture
    import z80fi_insn_capture_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    core_insn_start,
    input  logic                    core_fetch,
    input  logic [Z80FI_DATA_W-1:0] core_fetch_data,
    input  logic                    core_mem_wr,
    input  logic [Z80FI_ADDR_W-1:0] core_mem_waddr,
    input  logic [Z80FI_DATA_W-1:0] core_mem_wdata,
    input  logic                    core_insn_end,
    input  logic [Z80FI_REG_W-1:0]  core_ip,
    input  logic [Z80FI_REG_W-1:0]  core_bc,
    input  logic [Z80FI_REG_W-1:0]  core_de,
    input  logic [Z80FI_REG_W-1:0]  core_hl,
    input  logic [Z80FI_REG_W-1:0]  core_sp,
    output logic                    z80fi_valid,
    output logic [Z80FI_INSN_W-1:0] z80fi_insn,
    output logic [Z80FI_LEN_W-1:0]  z80fi_insn_len,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_ip_in,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_bc_in,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_de_in,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_hl_in,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_sp_in,
    output logic [Z80FI_REG_W-1:0]  z80fi_reg_ip_out,
    output logic                    z80fi_mem_wr,
    output logic [Z80FI_ADDR_W-1:0] z80fi_mem_waddr,
    output logic [Z80FI_DATA_W-1:0] z80fi_mem_wdata,
    output logic                    z80fi_mem_wr2,
    output logic [Z80FI_ADDR_W-1:0] z80fi_mem_waddr2,
    output logic [Z80FI_DATA_W-1:0] z80fi_mem_wdata2,
`ifdef Z80FI_MEM_RD_EN
    input  logic                    core_mem_rd,
    input  logic [Z80FI_ADDR_W-1:0] core_mem_raddr,
    input  logic [Z80FI_DATA_W-1:0] core_mem_rdata,
    output logic                    z80fi_mem_rd,
    output logic [Z80FI_ADDR_W-1:0] z80fi_mem_raddr,
    output logic [Z80FI_DATA_W-1:0] z80fi_mem_rdata,
    output logic                    z80fi_mem_rd2,
    output logic [Z80FI_ADDR_W-1:0] z80fi_mem_raddr2,
    output logic [Z80FI_DATA_W-1:0] z80fi_mem_rdata2,
`endif
    output logic                    capture_err
);

    localparam logic [Z80FI_LEN_W-1:0] LEN_MAX = Z80FI_LEN_W'(MAX_BYTES);

    state_e                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [Z80FI_INSN_W-1:0] buf_q, buf_d, pkt_insn_q, pkt_insn_d;
    logic [Z80FI_LEN_W-1:0]  len_q, len_d, pkt_len_q, pkt_len_d;
    regs_t                   snap_q, snap_d, pkt_regs_q, pkt_regs_d;
    logic [Z80FI_REG_W-1:0]  ip_out_q, ip_out_d;

    logic                    in_col, fin, clr, evt, fetch_acc, byte_ovf, stray, abort;
    logic                    wr_ovf, rd_ovf, rd_ev;
    logic [Z80FI_INSN_W-1:0] cur_buf, upd_buf;
    logic [Z80FI_LEN_W-1:0]  cur_len, upd_len;

`ifdef Z80FI_MEM_RD_EN
    assign rd_ev = core_mem_rd;
`else
    assign rd_ev  = 1'b0;
    assign rd_ovf = 1'b0;
`endif

    // Events accompanying core_insn_end belong to the retiring packet; with a
    // lone core_insn_start they belong to the new packet (clear-then-apply).
    always_comb begin
        in_col     = state_q == ST_COLLECT;
        fin        = in_col && core_insn_end;
        clr        = core_insn_start && !fin;
        evt        = in_col || core_insn_start;
        abort      = in_col && core_insn_start && !core_insn_end;
        stray      = !in_col && (core_insn_end ||
                     (!core_insn_start && (core_fetch || core_mem_wr || rd_ev)));
        cur_buf    = clr ? '0 : buf_q;
        cur_len    = clr ? '0 : len_q;
        fetch_acc  = evt && core_fetch;
        byte_ovf   = fetch_acc && cur_len == LEN_MAX;
        upd_buf    = (fetch_acc && !byte_ovf) ? put_byte(cur_buf, cur_len[1:0], core_fetch_data) : cur_buf;
        upd_len    = cur_len + Z80FI_LEN_W'(fetch_acc && !byte_ovf);
        state_d    = core_insn_start ? ST_COLLECT : (fin ? ST_IDLE : state_q);
        buf_d      = (core_insn_start && fin) ? '0 : upd_buf;
        len_d      = (core_insn_start && fin) ? '0 : upd_len;
        snap_d     = core_insn_start ? regs_t'{ip: core_ip, bc: core_bc, de: core_de, hl: core_hl, sp: core_sp} : snap_q;
        pkt_insn_d = fin ? upd_buf : (clr ? '0 : pkt_insn_q);
        pkt_len_d  = fin ? upd_len : (clr ? '0 : pkt_len_q);
        pkt_regs_d = fin ? snap_q : pkt_regs_q;
        ip_out_d   = fin ? core_ip : ip_out_q;
        valid_d    = fin;
        err_d      = err_q | stray | abort | byte_ovf | wr_ovf | rd_ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            buf_q      <= '0;
            len_q      <= '0;
            pkt_insn_q <= '0;
            pkt_len_q  <= '0;
            snap_q     <= '0;
            pkt_regs_q <= '0;
            ip_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            pkt_insn_q <= pkt_insn_d;
            pkt_len_q  <= pkt_len_d;
            snap_q     <= snap_d;
            pkt_regs_q <= pkt_regs_d;
            ip_out_q   <= ip_out_d;
        end
    end

    z80fi_access_slots u_wr_slots (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (core_insn_start),
        .fin      (fin),
        .acc      (evt && core_mem_wr),
        .acc_addr (core_mem_waddr),
        .acc_data (core_mem_wdata),
        .v1       (z80fi_mem_wr),
        .a1       (z80fi_mem_waddr),
        .d1       (z80fi_mem_wdata),
        .v2       (z80fi_mem_wr2),
        .a2       (z80fi_mem_waddr2),
        .d2       (z80fi_mem_wdata2),
        .ovf      (wr_ovf)
    );

`ifdef Z80FI_MEM_RD_EN
    z80fi_access_slots u_rd_slots (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (core_insn_start),
        .fin      (fin),
        .acc      (evt && core_mem_rd),
        .acc_addr (core_mem_raddr),
        .acc_data (core_mem_rdata),
        .v1       (z80fi_mem_rd),
        .a1       (z80fi_mem_raddr),
        .d1       (z80fi_mem_rdata),
        .v2       (z80fi_mem_rd2),
        .a2       (z80fi_mem_raddr2),
        .d2       (z80fi_mem_rdata2),
        .ovf      (rd_ovf)
    );
`endif

    assign z80fi_valid      = valid_q;
    assign z80fi_insn       = pkt_insn_q;
    assign z80fi_insn_len   = pkt_len_q;
    assign z80fi_reg_ip_in  = pkt_regs_q.ip;
    assign z80fi_reg_bc_in  = pkt_regs_q.bc;
    assign z80fi_reg_de_in  = pkt_regs_q.de;
    assign z80fi_reg_hl_in  = pkt_regs_q.hl;
    assign z80fi_reg_sp_in  = pkt_regs_q.sp;
    assign z80fi_reg_ip_out = ip_out_q;
    assign capture_err      = err_q;

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// tb_z80fi_insn_capture: directed scoreboard bench for z80fi_insn_capture.
module tb_z80fi_insn_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_insn_start = 1'b0, core_fetch = 1'b0, core_mem_wr = 1'b0, core_insn_end = 1'b0;
    logic [7:0]  core_fetch_data = '0, core_mem_wdata = '0;
    logic [15:0] core_mem_waddr = '0, core_ip = '0, core_bc = '0, core_de = '0, core_hl = '0, core_sp = '0;
    logic        z80fi_valid, z80fi_mem_wr, z80fi_mem_wr2, capture_err;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_reg_ip_in, z80fi_reg_bc_in, z80fi_reg_de_in, z80fi_reg_hl_in, z80fi_reg_sp_in;
    logic [15:0] z80fi_reg_ip_out, z80fi_mem_waddr, z80fi_mem_waddr2;
    logic [7:0]  z80fi_mem_wdata, z80fi_mem_wdata2;

    z80fi_insn_capture dut (
        .clk(clk), .reset_n(reset_n),
        .core_insn_start(core_insn_start), .core_fetch(core_fetch), .core_fetch_data(core_fetch_data),
        .core_mem_wr(core_mem_wr), .core_mem_waddr(core_mem_waddr), .core_mem_wdata(core_mem_wdata),
        .core_insn_end(core_insn_end), .core_ip(core_ip),
        .core_bc(core_bc), .core_de(core_de), .core_hl(core_hl), .core_sp(core_sp),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_bc_in(z80fi_reg_bc_in), .z80fi_reg_de_in(z80fi_reg_de_in),
        .z80fi_reg_hl_in(z80fi_reg_hl_in), .z80fi_reg_sp_in(z80fi_reg_sp_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
        .z80fi_mem_wr2(z80fi_mem_wr2), .z80fi_mem_waddr2(z80fi_mem_waddr2), .z80fi_mem_wdata2(z80fi_mem_wdata2),
        .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] ip_in, bc, de, hl, sp, ip_out;
        logic        wr;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        wr2;
        logic [15:0] wa2;
        logic [7:0]  wd2;
    } pkt_t;

    pkt_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (z80fi_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got valid=1 expected no packet");
            end else begin
                pkt_t p;
                p = sb.pop_front();
                chk("insn", z80fi_insn, p.insn);
                chk("len", 32'(z80fi_insn_len), 32'(p.len));
                chk("ip_in", 32'(z80fi_reg_ip_in), 32'(p.ip_in));
                chk("bc_in", 32'(z80fi_reg_bc_in), 32'(p.bc));
                chk("de_in", 32'(z80fi_reg_de_in), 32'(p.de));
                chk("hl_in", 32'(z80fi_reg_hl_in), 32'(p.hl));
                chk("sp_in", 32'(z80fi_reg_sp_in), 32'(p.sp));
                chk("ip_out", 32'(z80fi_reg_ip_out), 32'(p.ip_out));
                chk("wr", 32'(z80fi_mem_wr), 32'(p.wr));
                chk("wr2", 32'(z80fi_mem_wr2), 32'(p.wr2));
                if (p.wr) begin
                    chk("waddr", 32'(z80fi_mem_waddr), 32'(p.wa));
                    chk("wdata", 32'(z80fi_mem_wdata), 32'(p.wd));
                end
                if (p.wr2) begin
                    chk("waddr2", 32'(z80fi_mem_waddr2), 32'(p.wa2));
                    chk("wdata2", 32'(z80fi_mem_wdata2), 32'(p.wd2));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input logic s, input logic f, input logic [7:0] fd,
                        input logic w, input logic [15:0] wa, input logic [7:0] wd, input logic e);
        core_insn_start = s;
        core_fetch      = f;
        core_fetch_data = fd;
        core_mem_wr     = w;
        core_mem_waddr  = wa;
        core_mem_wdata  = wd;
        core_insn_end   = e;
        @(posedge clk);
        #1;
        core_insn_start = 1'b0;
        core_fetch      = 1'b0;
        core_mem_wr     = 1'b0;
        core_insn_end   = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] ip, input logic [15:0] bc, input logic [15:0] de,
                            input logic [15:0] hl, input logic [15:0] sp);
        core_ip = ip; core_bc = bc; core_de = de; core_hl = hl; core_sp = sp;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(z80fi_valid), 0);
        chk({tag, "_insn"}, z80fi_insn, 0);
        chk({tag, "_len"}, 32'(z80fi_insn_len), 0);
        chk({tag, "_wr"}, 32'(z80fi_mem_wr), 0);
        chk({tag, "_ip_out"}, 32'(z80fi_reg_ip_out), 0);
        chk({tag, "_err"}, 32'(capture_err), 0);
    endtask

    initial begin
        pkt_t p;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);

        // LD (0x1234),DE
        set_regs(16'h0100, 16'h1111, 16'hBEEF, 16'h2222, 16'hFFF0);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        core_ip = 16'h0101;
        step(0, 1, 8'hED, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h53, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h34, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h12, 0, 16'h0, 8'h00, 0);
        step(0, 0, 8'h00, 1, 16'h1234, 8'hEF, 0);
        step(0, 0, 8'h00, 1, 16'h1235, 8'hBE, 0);
        core_ip = 16'h0104;
        p = '{insn: 32'h123453ED, len: 3'd4, ip_in: 16'h0100, bc: 16'h1111, de: 16'hBEEF, hl: 16'h2222,
              sp: 16'hFFF0, ip_out: 16'h0104, wr: 1'b1, wa: 16'h1234, wd: 8'hEF, wr2: 1'b1, wa2: 16'h1235, wd2: 8'hBE};
        sb.push_back(p);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 1);
        chk("ld_valid_latency", 32'(z80fi_valid), 1);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("ld_valid_one_cycle", 32'(z80fi_valid), 0);
        chk("ld_hold_insn", z80fi_insn, 32'h123453ED);
        chk("ld_err", 32'(capture_err), 0);

        // NOP: start clears held packet, then fetch and end together
        set_regs(16'h0104, 16'h3333, 16'h4444, 16'h5555, 16'hFFEE);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("start_clr_insn", z80fi_insn, 0);
        chk("start_clr_len", 32'(z80fi_insn_len), 0);
        chk("start_clr_wr", 32'(z80fi_mem_wr), 0);
        core_ip = 16'h0105;
        p = '{insn: 32'h0, len: 3'd1, ip_in: 16'h0104, bc: 16'h3333, de: 16'h4444, hl: 16'h5555,
              sp: 16'hFFEE, ip_out: 16'h0105, wr: 1'b0, wa: 16'h0, wd: 8'h0, wr2: 1'b0, wa2: 16'h0, wd2: 8'h0};
        sb.push_back(p);
        step(0, 1, 8'h00, 0, 16'h0, 8'h00, 1);
        chk("nop_valid_latency", 32'(z80fi_valid), 1);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);

        // Back-to-back: LD A,42h then HALT with end+start in one cycle
        set_regs(16'h0200, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'hF000);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h3E, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h42, 0, 16'h0, 8'h00, 0);
        set_regs(16'h0202, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hEFFE);
        p = '{insn: 32'h0000423E, len: 3'd2, ip_in: 16'h0200, bc: 16'h0A0A, de: 16'h0B0B, hl: 16'h0C0C,
              sp: 16'hF000, ip_out: 16'h0202, wr: 1'b0, wa: 16'h0, wd: 8'h0, wr2: 1'b0, wa2: 16'h0, wd2: 8'h0};
        sb.push_back(p);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 1);
        step(0, 1, 8'h76, 0, 16'h0, 8'h00, 0);
        core_ip = 16'h0203;
        p = '{insn: 32'h00000076, len: 3'd1, ip_in: 16'h0202, bc: 16'hA1A1, de: 16'hB2B2, hl: 16'hC3C3,
              sp: 16'hEFFE, ip_out: 16'h0203, wr: 1'b0, wa: 16'h0, wd: 8'h0, wr2: 1'b0, wa2: 16'h0, wd2: 8'h0};
        sb.push_back(p);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 1);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("b2b_err", 32'(capture_err), 0);

        // Overflow: five fetches and three writes
        set_regs(16'h0300, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'hDD, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'hCB, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h05, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'hC6, 0, 16'h0, 8'h00, 0);
        chk("ovf_err_before", 32'(capture_err), 0);
        step(0, 1, 8'h99, 1, 16'h1000, 8'h01, 0);
        chk("ovf_byte_err", 32'(capture_err), 1);
        step(0, 0, 8'h00, 1, 16'h1001, 8'h02, 0);
        step(0, 0, 8'h00, 1, 16'h1002, 8'h03, 0);
        core_ip = 16'h0304;
        p = '{insn: 32'hC605CBDD, len: 3'd4, ip_in: 16'h0300, bc: 16'h0001, de: 16'h0002, hl: 16'h0003,
              sp: 16'h0004, ip_out: 16'h0304, wr: 1'b1, wa: 16'h1000, wd: 8'h01, wr2: 1'b1, wa2: 16'h1001, wd2: 8'h02};
        sb.push_back(p);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 1);
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("ovf_err_sticky", 32'(capture_err), 1);

        // Reset mid-collection: asynchronous, between clock edges
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h11, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h22, 0, 16'h0, 8'h00, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        core_insn_end = 1'b0;
        repeat (3) step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("midrst_no_valid_err", 32'(capture_err), 0);

        // Abort: restart without end drops the partial packet
        set_regs(16'h0400, 16'h1010, 16'h2020, 16'h3030, 16'h4040);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h01, 0, 16'h0, 8'h00, 0);
        step(0, 1, 8'h02, 0, 16'h0, 8'h00, 0);
        set_regs(16'h0410, 16'h5050, 16'h6060, 16'h7070, 16'h8080);
        step(1, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("abort_err", 32'(capture_err), 1);
        core_ip = 16'h0411;
        p = '{insn: 32'h000000C9, len: 3'd1, ip_in: 16'h0410, bc: 16'h5050, de: 16'h6060, hl: 16'h7070,
              sp: 16'h8080, ip_out: 16'h0411, wr: 1'b0, wa: 16'h0, wd: 8'h0, wr2: 1'b0, wa2: 16'h0, wd2: 8'h0};
        sb.push_back(p);
        step(0, 1, 8'hC9, 0, 16'h0, 8'h00, 1);
        repeat (2) step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);

        // Stray fetch in IDLE after a clean reset
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);
        chk("stray_err_before", 32'(capture_err), 0);
        step(0, 1, 8'hAA, 0, 16'h0, 8'h00, 0);
        chk("stray_err", 32'(capture_err), 1);
        repeat (3) step(0, 0, 8'h00, 0, 16'h0, 8'h00, 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
